dffram_lsu: RTL and testbench

Load/store initiator that drives the 256x32 DFFRAM macro port (CLK, EN, WE[3:0], A[7:0], Di, Do) on behalf of the core's data-memory interface. Accepts byte/half/word requests on a valid/ready handshake and generates the RAM enable, byte-write strobes, word address and lane-replicated write data. Captures the 1-cycle-latency read data and returns it aligned and sign/zero-extended on a valid/ready response channel. Rejects misaligned or illegal-size requests with an error response and no RAM access.

---
 rtl/dffram_lsu.sv | 146 ++++++++++++++
 tb/tb_dffram_lsu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dffram_lsu.sv
// Load/store initiator for the 256x32 DFFRAM macro.
// Handles one request at a time; misaligned or illegal sizes get an error response.
module dffram_lsu #(
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [7:0]    ram_a,
  output logic [31:0]   ram_di,
  input  logic [31:0]   ram_do
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;

  logic        bad;
  logic [3:0]  mask;
  logic [31:0] rep;
  logic [31:0] ext;
  logic [7:0]  rd_b;
  logic [15:0] rd_h;

  assign req_ready = (state == IDLE);

  always_comb begin
    bad  = 1'b0;
    mask = 4'h0;
    rep  = req_wdata;
    unique case (req_size)
      2'd0: begin
        mask = 4'b0001 << req_addr[1:0];
        rep  = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        bad  = req_addr[0];
        mask = req_addr[1] ? 4'b1100 : 4'b0011;
        rep  = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        bad  = |req_addr[1:0];
        mask = 4'hF;
      end
      default: bad = 1'b1;
    endcase
  end

  // Lane select and extension of the word returned by the macro.
  always_comb begin
    rd_b = ram_do[8*lane_q +: 8];
    rd_h = ram_do[16*lane_q[1] +: 16];
    ext  = ram_do;
    unique case (size_q)
      2'd0:    ext = {{24{~uns_q & rd_b[7]}}, rd_b};
      2'd1:    ext = {{16{~uns_q & rd_h[15]}}, rd_h};
      default: ext = ram_do;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      size_q    <= 2'd0;
      uns_q     <= 1'b0;
      lane_q    <= 2'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
      ram_en    <= 1'b0;
      ram_we    <= 4'h0;
      ram_a     <= 8'h0;
      ram_di    <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q   <= req_we;
            size_q <= req_size;
            uns_q  <= req_unsigned;
            lane_q <= req_addr[1:0];
            if (bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else begin
              state  <= ACCESS;
              ram_en <= 1'b1;
              ram_we <= req_we ? mask : 4'h0;
              ram_a  <= 8'(req_addr[AW-1:2]);
              ram_di <= rep;
            end
          end
        end
        ACCESS: begin
          ram_en <= 1'b0;
          ram_we <= 4'h0;
          if (we_q) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          rsp_rdata <= ext;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dffram_lsu.sv
// Randomized bench for dffram_lsu against a byte-array memory model.
// Includes a behavioural DFFRAM macro driven by the DUT.
module tb_dffram_lsu;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [9:0]  req_addr = 10'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [7:0]  ram_a;
  logic [31:0] ram_di;
  logic [31:0] ram_do = 32'h0;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] ram [256];
  logic [7:0]  mem [1024];

  always #5 CLK = ~CLK;

  dffram_lsu #(.AW(10)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a),
    .ram_di(ram_di), .ram_do(ram_do)
  );

  always @(posedge CLK) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) ram[ram_a][8*i +: 8] <= ram_di[8*i +: 8];
      ram_do <= ram[ram_a];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
  endtask

  task automatic xact(input logic we, input logic [1:0] sz,
                      input logic uns, input logic [9:0] a,
                      input logic [31:0] wd, input int hold);
    int nb, c, ens;
    logic err;
    logic [3:0] ewe;
    logic [31:0] edi, ed;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || ((int'(a) % nb) != 0);
    ewe = 4'h0;
    for (int i = 0; i < nb; i++) ewe[(int'(a) + i) % 4] = 1'b1;
    if (!we) ewe = 4'h0;
    edi = (sz == 2'd0) ? {4{wd[7:0]}} :
          (sz == 2'd1) ? {2{wd[15:0]}} : wd;
    ed = 32'h0;
    if (!err && !we) begin
      for (int i = 0; i < nb; i++)
        ed = ed | (32'(mem[int'(a) + i]) << (8 * i));
      if (!uns && nb < 4 && ed[8*nb-1])
        ed = ed | ~((32'h1 << (8 * nb)) - 32'h1);
    end
    @(negedge CLK);
    chk("req_ready_pre", 32'(req_ready), 32'd1);
    req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    c = 0; ens = 0;
    forever begin
      @(negedge CLK);
      c++;
      if (ram_en) begin
        ens++;
        chk("ram_a", 32'(ram_a), 32'(a[9:2]));
        chk("ram_we", 32'(ram_we), 32'(ewe));
        if (we) chk("ram_di", ram_di, edi);
      end else begin
        if (ram_we != 4'h0) chk("ram_we_idle", 32'(ram_we), 32'h0);
      end
      if (rsp_valid || c >= 8) break;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("latency", 32'(c), err ? 32'd1 : we ? 32'd2 : 32'd3);
    chk("rsp_err", 32'(rsp_err), 32'(err));
    chk("rsp_rdata", rsp_rdata, ed);
    chk("ram_en_cnt", 32'(ens), err ? 32'd0 : 32'd1);
    repeat (hold) begin
      @(negedge CLK);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, ed);
      chk("bp_err", 32'(rsp_err), 32'(err));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_ram_en", 32'(ram_en), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1 rsp_ready = 1'b0;
    @(negedge CLK);
    idle_outs("post");
    if (we && !err)
      for (int i = 0; i < nb; i++) mem[int'(a) + i] = wd[8*i +: 8];
  endtask

  task automatic reset_mid_load(input logic [9:0] a);
    @(negedge CLK);
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = a; req_valid = 1'b1;
    @(posedge CLK);
    #1 req_valid = 1'b0;
    @(negedge CLK);
    chk("rst_access_en", 32'(ram_en), 32'd1);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    idle_outs("rst_mid");
    chk("rst_ram_a", 32'(ram_a), 32'h0);
    chk("rst_ram_di", ram_di, 32'h0);
    repeat (3) begin
      @(negedge CLK);
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    idle_outs("reset");
    chk("reset_ram_a", 32'(ram_a), 32'h0);
    chk("reset_ram_di", ram_di, 32'h0);
    @(posedge CLK);
    #1 RST = 1'b0;

    xact(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 0);
    xact(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 0);
    xact(1'b1, 2'd0, 1'b0, 10'h013, 32'h00000080, 0);
    xact(1'b0, 2'd0, 1'b0, 10'h013, 32'h0, 0);
    xact(1'b0, 2'd0, 1'b1, 10'h013, 32'h0, 0);
    xact(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 0);
    xact(1'b1, 2'd1, 1'b0, 10'h022, 32'h00001234, 0);
    xact(1'b1, 2'd1, 1'b0, 10'h020, 32'h00008001, 0);
    xact(1'b0, 2'd1, 1'b0, 10'h020, 32'h0, 0);
    xact(1'b0, 2'd1, 1'b1, 10'h020, 32'h0, 0);
    xact(1'b0, 2'd1, 1'b0, 10'h021, 32'h0, 0);
    xact(1'b1, 2'd2, 1'b0, 10'h012, 32'hFFFFFFFF, 0);
    xact(1'b1, 2'd3, 1'b0, 10'h020, 32'hFFFFFFFF, 0);
    xact(1'b0, 2'd2, 1'b0, 10'h020, 32'h0, 0);
    xact(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 5);
    xact(1'b1, 2'd2, 1'b0, 10'h3FC, 32'hA5A55A5A, 0);
    xact(1'b0, 2'd0, 1'b0, 10'h3FF, 32'h0, 0);

    reset_mid_load(10'h010);
    xact(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 0);

    for (int k = 0; k < 120; k++) begin
      logic [9:0] a;
      a = 10'($urandom_range(0, 63));
      xact(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
           a, $urandom, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
